// File: rtl/wm_led_pkg.sv
// Shared types for the washing-machine LED sequencer: programme states,
// selection encodings and the registered LED bundle.
package wm_led_pkg;

  typedef enum logic [2:0] {
    S_LEVEL,
    S_TEMP,
    S_WASH,
    S_RINSE,
    S_DRY,
    S_DONE
  } state_t;

  localparam logic [1:0] LVL_LOW  = 2'd0;
  localparam logic [1:0] LVL_MID  = 2'd1;
  localparam logic [1:0] LVL_HIGH = 2'd2;

  localparam logic [1:0] TMP_HOT  = 2'd0;
  localparam logic [1:0] TMP_COLD = 2'd1;
  localparam logic [1:0] TMP_BOTH = 2'd2;

  typedef struct packed {
    logic wash;
    logic rinse;
    logic dry;
    logic water_height;
    logic hot_cold;
    logic water_high;
    logic water_mid;
    logic water_low;
    logic hot_only;
    logic cold_only;
    logic hot_and_cold;
  } led_t;

  // Selections above the top encoding saturate to the top encoding.
  function automatic logic [1:0] clamp_sel(input int unsigned v);
    if (v > 2) return 2'd2;
    return v[1:0];
  endfunction

endpackage

// File: rtl/wm_tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_CYCLES clocks.
module wm_tick_gen #(
  parameter int unsigned TICK_CYCLES = 125_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned TC = (TICK_CYCLES == 0) ? 1 : TICK_CYCLES;
  localparam int unsigned CW = (TC > 1) ? $clog2(TC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/wm_led_ctrl.sv
// Washing-machine front-panel LED sequencer running a fixed programme.
// Optional macro WM_LED_BLINK_EN makes the active wash/rinse/dry LED blink per tick.
module wm_led_ctrl
  import wm_led_pkg::*;
#(
  parameter int unsigned TICK_CYCLES  = 125_000_000,
  parameter int unsigned SEL_TICKS    = 3,
  parameter int unsigned WASH_TICKS   = 10,
  parameter int unsigned RINSE_TICKS  = 6,
  parameter int unsigned RINSE_REPEAT = 2,
  parameter int unsigned DRY_TICKS    = 8,
  parameter int unsigned WATER_LEVEL  = 2,
  parameter int unsigned TEMP_MODE    = 2
) (
  input  logic clk,
  input  logic reset,
  output logic red_led_wash,
  output logic red_led_rinse,
  output logic red_led_dry,
  output logic red_led_water_height,
  output logic red_led_hot_cold,
  output logic green_led_water_high,
  output logic green_led_water_mid,
  output logic green_led_water_low,
  output logic green_led_hot_only,
  output logic green_led_cold_only,
  output logic green_led_hot_cold
);

  localparam logic [31:0] SEL_DUR   = (SEL_TICKS == 0)    ? 32'd1 : 32'(SEL_TICKS);
  localparam logic [31:0] WASH_DUR  = (WASH_TICKS == 0)   ? 32'd1 : 32'(WASH_TICKS);
  localparam logic [31:0] RINSE_DUR = (RINSE_TICKS == 0)  ? 32'd1 : 32'(RINSE_TICKS);
  localparam logic [31:0] DRY_DUR   = (DRY_TICKS == 0)    ? 32'd1 : 32'(DRY_TICKS);
  localparam logic [31:0] PASSES    = (RINSE_REPEAT == 0) ? 32'd1 : 32'(RINSE_REPEAT);
  localparam logic [1:0]  LEVEL_SEL = clamp_sel(WATER_LEVEL);
  localparam logic [1:0]  TEMP_SEL  = clamp_sel(TEMP_MODE);

  state_t      state, next_state;
  logic [31:0] phase_cnt, pass_cnt, dur;
  logic        tick, last_tick, last_pass, phase_on;
  logic        water_on, temp_on;
  led_t        led_d, led_q;

  wm_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_LEVEL;
      phase_cnt <= '0;
      pass_cnt  <= '0;
    end else begin
      state <= next_state;
      if (last_tick) begin
        phase_cnt <= '0;
      end else if (tick && state != S_DONE) begin
        phase_cnt <= phase_cnt + 32'd1;
      end
      if (last_tick && state == S_RINSE) begin
        pass_cnt <= last_pass ? 32'd0 : pass_cnt + 32'd1;
      end
    end
  end

`ifdef WM_LED_BLINK_EN
  logic blink_off;

  // Blink phase restarts on every state entry so the LED is lit first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_off <= 1'b0;
    end else if (next_state != state) begin
      blink_off <= 1'b0;
    end else if (tick) begin
      blink_off <= ~blink_off;
    end
  end

  assign phase_on = ~blink_off;
`else
  assign phase_on = 1'b1;
`endif

  always_comb begin
    dur        = 32'd1;
    next_state = state;
    led_d      = '0;
    water_on   = 1'b0;
    temp_on    = 1'b0;

    case (state)
      S_LEVEL, S_TEMP: dur = SEL_DUR;
      S_WASH:          dur = WASH_DUR;
      S_RINSE:         dur = RINSE_DUR;
      S_DRY:           dur = DRY_DUR;
      default:         dur = 32'd1;
    endcase

    last_tick = tick && (state != S_DONE) && (phase_cnt == dur - 32'd1);
    last_pass = (pass_cnt == PASSES - 32'd1);

    if (last_tick) begin
      case (state)
        S_LEVEL: next_state = S_TEMP;
        S_TEMP:  next_state = S_WASH;
        S_WASH:  next_state = S_RINSE;
        S_RINSE: next_state = last_pass ? S_DRY : S_RINSE;
        S_DRY:   next_state = S_DONE;
        default: next_state = S_DONE;
      endcase
    end

    case (state)
      S_LEVEL: begin
        led_d.water_height = 1'b1;
        water_on           = 1'b1;
      end
      S_TEMP: begin
        led_d.hot_cold = 1'b1;
        water_on       = 1'b1;
        temp_on        = 1'b1;
      end
      S_WASH: begin
        led_d.wash = phase_on;
        water_on   = 1'b1;
        temp_on    = 1'b1;
      end
      S_RINSE: begin
        led_d.rinse = phase_on;
        water_on    = 1'b1;
        temp_on     = 1'b1;
      end
      S_DRY: begin
        led_d.dry = phase_on;
        water_on  = 1'b1;
        temp_on   = 1'b1;
      end
      default: begin
        led_d.wash  = 1'b1;
        led_d.rinse = 1'b1;
        led_d.dry   = 1'b1;
      end
    endcase

    led_d.water_high   = water_on && (LEVEL_SEL == LVL_HIGH);
    led_d.water_mid    = water_on && (LEVEL_SEL == LVL_MID);
    led_d.water_low    = water_on && (LEVEL_SEL == LVL_LOW);
    led_d.hot_only     = temp_on && (TEMP_SEL == TMP_HOT);
    led_d.cold_only    = temp_on && (TEMP_SEL == TMP_COLD);
    led_d.hot_and_cold = temp_on && (TEMP_SEL == TMP_BOTH);
  end

  // Registered decode: the panel shows the state one clock after it changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign red_led_wash         = led_q.wash;
  assign red_led_rinse        = led_q.rinse;
  assign red_led_dry          = led_q.dry;
  assign red_led_water_height = led_q.water_height;
  assign red_led_hot_cold     = led_q.hot_cold;
  assign green_led_water_high = led_q.water_high;
  assign green_led_water_mid  = led_q.water_mid;
  assign green_led_water_low  = led_q.water_low;
  assign green_led_hot_only   = led_q.hot_only;
  assign green_led_cold_only  = led_q.cold_only;
  assign green_led_hot_cold   = led_q.hot_and_cold;

endmodule

// File: tb/tb_wm_led_ctrl.sv
// Directed bench for wm_led_ctrl with TICK_CYCLES=4; a second instance uses
// WATER_LEVEL=0 / TEMP_MODE=1. LED vectors are {wash,rinse,dry,wh,hc,gh,gm,gl,gho,gco,ghc}.
module tb_wm_led_ctrl;

  localparam logic [10:0] V_ZERO  = 11'b000_00_000_000;
  localparam logic [10:0] V_LEVEL = 11'b000_10_100_000;
  localparam logic [10:0] V_TEMP  = 11'b000_01_100_001;
  localparam logic [10:0] V_WASH  = 11'b100_00_100_001;
  localparam logic [10:0] V_WOFF  = 11'b000_00_100_001;
  localparam logic [10:0] V_RINSE = 11'b010_00_100_001;
  localparam logic [10:0] V_DRY   = 11'b001_00_100_001;
  localparam logic [10:0] V_DONE  = 11'b111_00_000_000;
  localparam logic [10:0] VB_LEVEL = 11'b000_10_001_000;
  localparam logic [10:0] VB_TEMP  = 11'b000_01_001_010;
  localparam logic [10:0] VB_WASH  = 11'b100_00_001_010;

  logic clk;
  logic reset;
  logic a_wash, a_rinse, a_dry, a_wh, a_hc, a_gh, a_gm, a_gl, a_gho, a_gco, a_ghc;
  logic b_wash, b_rinse, b_dry, b_wh, b_hc, b_gh, b_gm, b_gl, b_gho, b_gco, b_ghc;
  int   errors = 0;
  int   checks = 0;
  int   cur_edge = 0;

  wm_led_ctrl #(.TICK_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .red_led_wash(a_wash), .red_led_rinse(a_rinse), .red_led_dry(a_dry),
    .red_led_water_height(a_wh), .red_led_hot_cold(a_hc),
    .green_led_water_high(a_gh), .green_led_water_mid(a_gm), .green_led_water_low(a_gl),
    .green_led_hot_only(a_gho), .green_led_cold_only(a_gco), .green_led_hot_cold(a_ghc)
  );

  wm_led_ctrl #(.TICK_CYCLES(4), .WATER_LEVEL(0), .TEMP_MODE(1)) dut_b (
    .clk(clk), .reset(reset),
    .red_led_wash(b_wash), .red_led_rinse(b_rinse), .red_led_dry(b_dry),
    .red_led_water_height(b_wh), .red_led_hot_cold(b_hc),
    .green_led_water_high(b_gh), .green_led_water_mid(b_gm), .green_led_water_low(b_gl),
    .green_led_hot_only(b_gho), .green_led_cold_only(b_gco), .green_led_hot_cold(b_ghc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] leds_a();
    return {a_wash, a_rinse, a_dry, a_wh, a_hc, a_gh, a_gm, a_gl, a_gho, a_gco, a_ghc};
  endfunction

  function automatic logic [10:0] leds_b();
    return {b_wash, b_rinse, b_dry, b_wh, b_hc, b_gh, b_gm, b_gl, b_gho, b_gco, b_ghc};
  endfunction

  // Edges are counted from reset release; sampling is 1 ns after the edge.
  task automatic advance_to(input int k);
    while (cur_edge < k) begin
      @(posedge clk);
      cur_edge++;
    end
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset    = 1'b0;
    cur_edge = 0;
  endtask

  task automatic test_reset();
    int          edges[5] = '{1, 12, 13, 24, 25};
    logic [10:0] want[5]  = '{V_LEVEL, V_LEVEL, V_TEMP, V_TEMP, V_WASH};
    reset = 1'b1;
    #500;
    checks++;
    if (leds_a() !== V_ZERO) begin
      errors++;
      $display("[TB] FAIL reset_mid got=%b want=%b", leds_a(), V_ZERO);
    end
    #500;
    checks++;
    if (leds_a() !== V_ZERO || leds_b() !== V_ZERO) begin
      errors++;
      $display("[TB] FAIL reset_end got=%b/%b want=%b", leds_a(), leds_b(), V_ZERO);
    end
    release_reset();
    for (int i = 0; i < 5; i++) begin
      advance_to(edges[i]);
      checks++;
      if (leds_a() !== want[i]) begin
        errors++;
        $display("[TB] FAIL seq_edge%0d got=%b want=%b", edges[i], leds_a(), want[i]);
      end
    end
  endtask

  task automatic test_levels();
    for (int e = 26; e <= 64; e += 6) begin
      advance_to(e);
      checks++;
      if (leds_b() !== VB_WASH) begin
        errors++;
        $display("[TB] FAIL levels_wash_edge%0d got=%b want=%b", e, leds_b(), VB_WASH);
      end
    end
  endtask

  task automatic test_mid_reset();
    advance_to(80);
    checks++;
    if (leds_a() !== V_RINSE) begin
      errors++;
      $display("[TB] FAIL pre_reset_rinse got=%b want=%b", leds_a(), V_RINSE);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (leds_a() !== V_ZERO || leds_b() !== V_ZERO) begin
      errors++;
      $display("[TB] FAIL async_clear got=%b/%b want=%b", leds_a(), leds_b(), V_ZERO);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (leds_a() !== V_ZERO) begin
      errors++;
      $display("[TB] FAIL reset_hold got=%b want=%b", leds_a(), V_ZERO);
    end
    release_reset();
    for (int e = 1; e <= 12; e++) begin
      advance_to(e);
      checks++;
      if (leds_a() !== V_LEVEL || leds_b() !== VB_LEVEL) begin
        errors++;
        $display("[TB] FAIL restart_level_edge%0d got=%b/%b want=%b/%b",
                 e, leds_a(), leds_b(), V_LEVEL, VB_LEVEL);
      end
    end
    advance_to(13);
    checks++;
    if (leds_a() !== V_TEMP || leds_b() !== VB_TEMP) begin
      errors++;
      $display("[TB] FAIL restart_temp got=%b/%b want=%b/%b", leds_a(), leds_b(), V_TEMP, VB_TEMP);
    end
  endtask

  task automatic test_blink();
    logic [10:0] want;
    for (int e = 25; e <= 48; e++) begin
      advance_to(e);
`ifdef WM_LED_BLINK_EN
      want = (((e - 25) / 4) % 2 == 0) ? V_WASH : V_WOFF;
`else
      want = V_WASH;
`endif
      checks++;
      if (leds_a() !== want) begin
        errors++;
        $display("[TB] FAIL wash_blink_edge%0d got=%b want=%b", e, leds_a(), want);
      end
    end
  endtask

  task automatic test_full_run();
    int          edges[8] = '{64, 65, 88, 89, 112, 113, 144, 145};
    logic [10:0] want[8]  = '{V_WASH, V_RINSE, V_RINSE, V_RINSE, V_RINSE, V_DRY, V_DRY, V_DONE};
    logic [10:0] w;
    for (int i = 0; i < 8; i++) begin
      advance_to(edges[i]);
      w = want[i];
`ifdef WM_LED_BLINK_EN
      if (edges[i] == 64) w = V_WOFF;
      if (edges[i] == 144) w = 11'b000_00_100_001;
`endif
      checks++;
      if (leds_a() !== w) begin
        errors++;
        $display("[TB] FAIL run_edge%0d got=%b want=%b", edges[i], leds_a(), w);
      end
    end
    for (int e = 146; e <= 345; e++) begin
      advance_to(e);
      checks++;
      if (leds_a() !== V_DONE) begin
        errors++;
        $display("[TB] FAIL done_hold_edge%0d got=%b want=%b", e, leds_a(), V_DONE);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_levels();
    test_mid_reset();
    test_blink();
    test_full_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
